// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative signed-magnitude restoring divider
// One quotient bit per clock, MSB first, with start/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [M-1:0]  dvd;
  logic [M-1:0]  dvs;
  logic [M-1:0]  prem;
  logic [M-1:0]  qacc;
  logic          sign_q;
  logic          sign_r;

  logic [M:0]    shifted;
  logic [M:0]    trial;
  logic          qbit;
  logic [M-1:0]  prem_next;
  logic [M-1:0]  q_next;

  // Since prem < dvs, a borrow shows up as trial[M]; on no borrow trial fits in M bits.
  always_comb begin
    shifted   = {prem, dvd[M-1]};
    trial     = shifted - {1'b0, dvs};
    qbit      = ~trial[M];
    prem_next = qbit ? trial[M-1:0] : shifted[M-1:0];
    q_next    = {qacc[M-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      qacc        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd       <= dividend[M-1:0];
            dvs       <= divisor[M-1:0];
            sign_q    <= dividend[M] ^ divisor[M];
            sign_r    <= dividend[M];
            prem      <= '0;
            qacc      <= '0;
            count     <= CW'(M);
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b1;
            if (divisor[M-1:0] == '0) begin
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          prem  <= prem_next;
          qacc  <= q_next;
          dvd   <= {dvd[M-2:0], 1'b0};
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state     <= DONE;
            done      <= 1'b1;
            // Zero magnitudes are forced positive so no -0 ever leaves the block.
            quotient  <= {sign_q & (|q_next), q_next};
            remainder <= {sign_r & (|prem_next), prem_next};
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed bench for seq_divider
// Expected results are queued at stimulus time and compared on each done pulse.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] q, input logic [7:0] r, input logic dbz);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    exp_q.push_back(e);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [6:0] qm, rm;
    if (b[6:0] == 7'd0) begin
      e.q = 8'h00; e.r = 8'h00; e.dbz = 1'b1;
    end else begin
      qm = a[6:0] / b[6:0];
      rm = a[6:0] % b[6:0];
      e.q = {(a[7] ^ b[7]) && (qm != 7'd0), qm};
      e.r = {a[7] && (rm != 7'd0), rm};
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Counts cycles after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int lat);
    int n, nb;
    exp_t e;
    e = model(a, b);
    exp_q.push_back(e);
    start_op(a, b);
    wait_done(n, nb);
    chk("latency", 32'(n), 32'(lat));
    @(negedge clk);
  endtask

  initial begin
    int n, nb;
    logic saw;
    logic [7:0] ra, rb;

    rst = 1'b1;
    start = 1'b0;
    dividend = 8'h00;
    divisor = 8'h00;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 7 / 2: latency and busy duration
    push(8'h03, 8'h01, 1'b0);
    start_op(8'h07, 8'h02);
    wait_done(n, nb);
    chk("latency_7_2", 32'(n), 32'd8);
    chk("busy_cycles_7_2", 32'(nb), 32'd8);
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);

    // Sign handling
    push(8'h86, 8'h82, 1'b0);
    start_op(8'h94, 8'h03);
    wait_done(n, nb);
    @(negedge clk);
    push(8'h86, 8'h02, 1'b0);
    start_op(8'h14, 8'h83);
    wait_done(n, nb);
    @(negedge clk);
    push(8'h00, 8'h00, 1'b0);
    start_op(8'h80, 8'h85);
    wait_done(n, nb);
    @(negedge clk);
    push(8'h7F, 8'h00, 1'b0);
    start_op(8'h7F, 8'h01);
    wait_done(n, nb);
    @(negedge clk);

    // Divide by -0, then a normal op must clear div_by_zero
    push(8'h00, 8'h00, 1'b1);
    start_op(8'h05, 8'h80);
    wait_done(n, nb);
    chk("latency_dbz", 32'(n), 32'd1);
    chk("busy_cycles_dbz", 32'(nb), 32'd1);
    @(negedge clk);
    push(8'h05, 8'h00, 1'b0);
    start_op(8'h05, 8'h01);
    wait_done(n, nb);
    @(negedge clk);

    // Start pulses during RUN and DONE are ignored
    push(8'h0C, 8'h07, 1'b0);
    start_op(8'h7F, 8'h0A);
    repeat (3) @(negedge clk);
    start_op(8'h01, 8'h01);
    wait_done(n, nb);
    chk("latency_ignore_run", 32'(n), 32'd5);
    start_op(8'h01, 8'h01);
    @(negedge clk);
    chk("ignore_done_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ignore_done_busy1", 32'(busy), 32'd0);

    // Start held high: new op accepted once back in IDLE
    push(8'h04, 8'h01, 1'b0);
    dividend = 8'h09;
    divisor  = 8'h02;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = 8'h1F;
    divisor  = 8'h85;
    push(8'h86, 8'h01, 1'b0);
    wait_done(n, nb);
    chk("latency_held_1", 32'(n), 32'd8);
    @(posedge clk);
    @(negedge clk);
    chk("held_idle_gap", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, nb);
    chk("latency_held_2", 32'(n), 32'd8);
    @(negedge clk);

    // Asynchronous reset mid-RUN
    start_op(8'h7F, 8'h0A);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_quotient", 32'(quotient), 32'd0);
    chk("arst_remainder", 32'(remainder), 32'd0);
    chk("arst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("no_done_after_arst", 32'(saw), 32'd0);
    push(8'h03, 8'h00, 1'b0);
    start_op(8'h09, 8'h03);
    wait_done(n, nb);
    chk("latency_after_arst", 32'(n), 32'd8);
    @(negedge clk);

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 0) rb = 8'h00;
      run_op(ra, rb, (rb[6:0] == 7'd0) ? 1 : 8);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative signed-magnitude integer divider for the calculator datapath.
- It is the inverse operation to the multiplier path.
- Operands arrive as bytes from the C++ host. Bit WIDTH-1 is the sign and the low WIDTH-1 bits are the magnitude.
- It produces quotient and remainder in the same format using restoring division, one quotient bit per clock, with a start/done handshake.

Parameters:
- WIDTH, 8, total operand and result width including the sign bit. Magnitude width is M = WIDTH-1.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a division. Sampled only when busy=0.
- dividend  in  WIDTH  signed-magnitude dividend. Captured on the accepting edge.
- divisor  in  WIDTH  signed-magnitude divisor. Captured on the accepting edge.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse: results are valid and complete.
- quotient  out  WIDTH  signed-magnitude quotient. Held until the next accepted start.
- remainder  out  WIDTH  signed-magnitude remainder. Held until the next accepted start.
- div_by_zero  out  1  set with done when the divisor magnitude is 0. Held until the next accepted start.

Behaviour:
- Reset: asynchronous and active-high. It applies immediately at any time, including mid-RUN. On reset:
  - state = IDLE and the step counter is 0.
  - busy, done and div_by_zero are 0.
  - quotient and remainder are 0.
  - An in-flight operation is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 on a rising edge accepts the operands.
  - The edge latches both magnitudes and both sign bits, and clears quotient, remainder and div_by_zero.
  - If divisor[M-1:0]==0, go to DONE with div_by_zero=1 and quotient = remainder = 0. This applies to +0 and -0.
  - Otherwise load partial remainder = 0 and counter = M, then go to RUN.
- RUN, one step per edge, MSB first:
  - Form trial = {partial_rem, next dividend magnitude bit} - divisor magnitude, using M+1 bits.
  - If trial >= 0, partial_rem = trial and the quotient bit is 1. Otherwise restore: partial_rem = the shifted value and the quotient bit is 0.
  - Decrement the counter. The edge that completes step M moves to DONE.
- DONE:
  - Lasts exactly one cycle with done=1, then returns to IDLE unconditionally.
  - Output registers are written on the edge that enters DONE.
- Latency:
  - Call the accepting edge E0. Normal case: done is high in the cycle after edge E0+M (M=7 for WIDTH=8).
  - Divide-by-zero: done is high in the cycle after E0.
  - Next earliest accept: the edge after the done cycle.
- Sign rules:
  - Quotient sign = dividend sign XOR divisor sign.
  - Remainder sign = dividend sign (truncating division), so |remainder| < |divisor|.
  - A zero magnitude result always gets sign 0; no -0 is produced.
  - -0 inputs are treated as magnitude 0.
- Handshake:
  - start while busy=1 is ignored, including in the DONE cycle. Operands are not re-sampled.
  - start may be held high continuously; each return to IDLE accepts a new operation.
  - Operand inputs may change freely after E0.
- Range: |quotient| <= |dividend| <= 2^M - 1, so no overflow is possible.

Test Plan:
- dividend=0x07 (7), divisor=0x02 (2), start pulse -> done exactly 8 cycles after the start cycle (the cycle after edge E0+7), quotient=0x03, remainder=0x01, div_by_zero=0; busy high for 8 cycles.
- dividend=0x94 (-20), divisor=0x03 (+3) -> quotient=0x86 (-6), remainder=0x82 (-2). Also dividend=0x14, divisor=0x83 -> quotient=0x86, remainder=0x02.
- dividend=0x80 (-0), divisor=0x85 (-5) -> quotient=0x00, remainder=0x00, no negative zero. Also 0x7F/0x01 -> quotient=0x7F, remainder=0x00.
- dividend=0x05, divisor=0x80 -> done in the cycle after the accepting edge, div_by_zero=1, quotient=0x00, remainder=0x00. A following 0x05/0x01 must clear div_by_zero and give quotient=0x05.
- Start 0x7F/0x0A, then pulse start with 0x01/0x01 during RUN and during DONE -> second request ignored, result 0x0C/0x07. With start held high, a new op is accepted the edge after done.
- Assert rst asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately and no done pulse. After release, 0x09/0x03 -> quotient=0x03, remainder=0x00.
